// File: rtl/md5_pkg.sv
// Shared constants, FSM state type and byte-placement helper for the MD5 block padder.
package md5_pkg;

  localparam int unsigned MD5_BLOCK_BITS = 512;
  localparam int unsigned MD5_MAX_BYTES  = 55;
  localparam logic [7:0]  MD5_PAD_BYTE   = 8'h80;

  typedef enum logic [1:0] {
    LOAD,
    FINAL,
    HOLD
  } md5_state_e;

  // md5core byte-swaps each 32-bit word, so byte 0 sits in the top lane of word 0.
  function automatic int unsigned byte_lsb(input int unsigned i);
    return 32 * (i / 4) + 8 * (3 - (i % 4));
  endfunction

endpackage

// File: rtl/md5_pad_block.sv
// Builds one padded single-block MD5 message (1..55 bytes) from a byte stream.
// Optional over-length error reporting via `define MD5_PAD_ERR_EN (adds len_err port).
module md5_pad_block
  import md5_pkg::*;
#(
  parameter int unsigned MAX_BYTES = MD5_MAX_BYTES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                in_byte,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [MD5_BLOCK_BITS-1:0] mesg_out,
  output logic                      mesg_valid,
  input  logic                      mesg_ready
`ifdef MD5_PAD_ERR_EN
  ,
  output logic                      len_err
`endif
);

  localparam logic [5:0] MAX_CNT = 6'(MAX_BYTES);

  md5_state_e  state;
  logic [7:0]  buf_q [64];
  logic [5:0]  cnt;
  logic        ovf;
  logic [15:0] bitlen;

  assign bitlen = {7'd0, cnt, 3'd0};

  for (genvar g = 0; g < 64; g++) begin : g_place
    assign mesg_out[byte_lsb(g) +: 8] = buf_q[g];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LOAD;
      for (int unsigned i = 0; i < 64; i++) buf_q[i] <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      in_ready   <= 1'b1;
      mesg_valid <= 1'b0;
`ifdef MD5_PAD_ERR_EN
      len_err    <= 1'b0;
`endif
    end else begin
`ifdef MD5_PAD_ERR_EN
      len_err <= 1'b0;
`endif
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            // Once full, further bytes are dropped and cnt stays at MAX_BYTES.
            if (!ovf && cnt < MAX_CNT) begin
              buf_q[cnt] <= in_byte;
              cnt        <= cnt + 6'd1;
            end else begin
              ovf <= 1'b1;
            end
            if (in_last) begin
              state    <= FINAL;
              in_ready <= 1'b0;
            end
          end
        end

        FINAL: begin
`ifdef MD5_PAD_ERR_EN
          if (ovf) begin
            len_err  <= 1'b1;
            for (int unsigned i = 0; i < 64; i++) buf_q[i] <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            state    <= LOAD;
            in_ready <= 1'b1;
          end else
`endif
          begin
            buf_q[cnt] <= MD5_PAD_BYTE;
            buf_q[56]  <= bitlen[7:0];
            buf_q[57]  <= bitlen[15:8];
            state      <= HOLD;
            mesg_valid <= 1'b1;
          end
        end

        HOLD: begin
          if (mesg_ready) begin
            for (int unsigned i = 0; i < 64; i++) buf_q[i] <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            state      <= LOAD;
            mesg_valid <= 1'b0;
            in_ready   <= 1'b1;
          end
        end

        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_pad_block.sv
// Self-checking bench for md5_pad_block; honours `define MD5_PAD_ERR_EN like the design.
module tb_md5_pad_block;
  import md5_pkg::*;

  logic         clk;
  logic         reset;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [511:0] mesg_out;
  logic         mesg_valid;
  logic         mesg_ready;
`ifdef MD5_PAD_ERR_EN
  logic         len_err;
`endif

  int errors = 0;
  int checks = 0;

  md5_pad_block #(.MAX_BYTES(55)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mesg_out   (mesg_out),
    .mesg_valid (mesg_valid),
    .mesg_ready (mesg_ready)
`ifdef MD5_PAD_ERR_EN
    ,
    .len_err    (len_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncate to 55 bytes, append 0x80, 64-bit little-endian bit length at 56..63.
  function automatic logic [511:0] model_block(input logic [7:0] m[$]);
    logic [7:0]   b [64];
    logic [63:0]  bits;
    logic [511:0] r;
    int unsigned  n;
    n = (m.size() > 55) ? 55 : m.size();
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    for (int i = 0; i < int'(n); i++) b[i] = m[i];
    b[n] = 8'h80;
    bits = 64'(8 * n);
    for (int k = 0; k < 8; k++) b[56 + k] = bits[8*k +: 8];
    r = '0;
    for (int i = 0; i < 64; i++) r[32*(i/4) + 8*(3-(i%4)) +: 8] = b[i];
    return r;
  endfunction

  // Called at a negedge; returns at the negedge right after the final transfer.
  task automatic send_msg(input logic [7:0] m[$], input int unsigned max_gap, input bit with_last);
    int tries;
    for (int k = 0; k < m.size(); k++) begin
      repeat ($urandom_range(0, max_gap)) begin
        in_valid = 1'b0;
        in_last  = $urandom_range(0, 1);
        in_byte  = 8'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_byte  = m[k];
      in_last  = with_last && (k == m.size() - 1);
      tries = 0;
      while (in_ready !== 1'b1 && tries < 200) begin
        @(negedge clk);
        tries++;
      end
      if (tries >= 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: byte %0d never accepted, in_ready=%b required 1", k, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_byte = '0; mesg_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++;
    if (mesg_valid !== 1'b0) begin errors++; $display("FAIL reset_mesg_valid: got %b required 0", mesg_valid); end
    checks++;
    if (mesg_out !== '0) begin errors++; $display("FAIL reset_mesg_out: got %h required 0", mesg_out); end
`ifdef MD5_PAD_ERR_EN
    checks++;
    if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b required 0", len_err); end
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abc(input int unsigned max_gap, input string tag);
    logic [7:0]   m[$];
    logic [511:0] exp;
    m = '{8'h61, 8'h62, 8'h63};
    exp = '0;
    exp[31:0]    = 32'h61626380;
    exp[479:448] = 32'h18000000;
    send_msg(m, max_gap, 1'b1);
    checks++;
    if (mesg_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL %s_final_cycle: valid=%b ready=%b required 0 0", tag, mesg_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (mesg_valid !== 1'b1) begin errors++; $display("FAIL %s_latency: mesg_valid=%b required 1", tag, mesg_valid); end
    checks++;
    if (mesg_out !== exp) begin errors++; $display("FAIL %s_block: got %h required %h", tag, mesg_out, exp); end
    checks++;
    if (mesg_out[31:0] !== 32'h61626380) begin
      errors++; $display("FAIL %s_word0: got %h required 61626380", tag, mesg_out[31:0]);
    end
    mesg_ready = 1'b1;
    @(negedge clk);
    mesg_ready = 1'b0;
    checks++;
    if (mesg_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s_handshake: valid=%b ready=%b required 0 1", tag, mesg_valid, in_ready);
    end
  endtask

  task automatic test_max55;
    logic [7:0] m[$];
    for (int i = 0; i < 55; i++) m.push_back(8'h41);
    send_msg(m, 0, 1'b1);
    @(negedge clk);
    checks++;
    if (mesg_valid !== 1'b1) begin errors++; $display("FAIL max55_valid: got %b required 1", mesg_valid); end
    checks++;
    if (mesg_out !== model_block(m)) begin
      errors++; $display("FAIL max55_block: got %h required %h", mesg_out, model_block(m));
    end
    checks++;
    if (mesg_out[479:464] !== 16'hB801) begin errors++; $display("FAIL max55_len: got %h required b801", mesg_out[479:464]); end
    checks++;
    if (mesg_out[447:416] !== 32'h41414180) begin
      errors++; $display("FAIL max55_word13: got %h required 41414180", mesg_out[447:416]);
    end
    mesg_ready = 1'b1;
    @(negedge clk);
    mesg_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [7:0]   m[$];
    logic [511:0] snap;
    int           bad;
    for (int i = 0; i < 5; i++) m.push_back(8'($urandom));
    send_msg(m, 1, 1'b1);
    @(negedge clk);
    snap = mesg_out;
    checks++;
    if (snap !== model_block(m)) begin errors++; $display("FAIL bp_block: got %h required %h", snap, model_block(m)); end
    in_valid = 1'b1; in_byte = 8'h55; in_last = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (mesg_out !== snap || in_ready !== 1'b0 || mesg_valid !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, required 0", bad); end
    in_valid = 1'b0; in_last = 1'b0;
    mesg_ready = 1'b1;
    @(negedge clk);
    mesg_ready = 1'b0;
    m = '{8'h61};
    send_msg(m, 0, 1'b1);
    @(negedge clk);
    checks++;
    if (mesg_out[31:0] !== 32'h61800000) begin
      errors++; $display("FAIL bp_followup_word0: got %h required 61800000", mesg_out[31:0]);
    end
    checks++;
    if (mesg_out !== model_block(m)) begin
      errors++; $display("FAIL bp_followup_block: got %h required %h", mesg_out, model_block(m));
    end
    mesg_ready = 1'b1;
    @(negedge clk);
    mesg_ready = 1'b0;
  endtask

  task automatic test_overlength;
    logic [7:0] m[$];
    for (int i = 0; i < 60; i++) m.push_back(8'(i + 1));
    send_msg(m, 0, 1'b1);
    @(negedge clk);
`ifdef MD5_PAD_ERR_EN
    checks++;
    if (len_err !== 1'b1 || mesg_valid !== 1'b0) begin
      errors++; $display("FAIL ovl_pulse: len_err=%b valid=%b required 1 0", len_err, mesg_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ovl_back_to_load: in_ready=%b required 1", in_ready); end
    @(negedge clk);
    checks++;
    if (len_err !== 1'b0) begin errors++; $display("FAIL ovl_pulse_width: len_err=%b required 0", len_err); end
    repeat (4) @(negedge clk);
    checks++;
    if (mesg_valid !== 1'b0 || mesg_out !== '0) begin
      errors++; $display("FAIL ovl_no_block: valid=%b out=%h required 0 0", mesg_valid, mesg_out);
    end
`else
    checks++;
    if (mesg_valid !== 1'b1) begin errors++; $display("FAIL ovl_valid: got %b required 1", mesg_valid); end
    checks++;
    if (mesg_out !== model_block(m)) begin
      errors++; $display("FAIL ovl_block: got %h required %h", mesg_out, model_block(m));
    end
    checks++;
    if (mesg_out[479:464] !== 16'hB801) begin errors++; $display("FAIL ovl_len: got %h required b801", mesg_out[479:464]); end
    mesg_ready = 1'b1;
    @(negedge clk);
    mesg_ready = 1'b0;
`endif
  endtask

  task automatic test_reset_mid;
    logic [7:0] m[$];
    m = '{8'hde, 8'had, 8'hbe};
    send_msg(m, 0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || mesg_valid !== 1'b0 || mesg_out !== '0) begin
      errors++; $display("FAIL midreset_state: ready=%b valid=%b out=%h required 1 0 0", in_ready, mesg_valid, mesg_out);
    end
    test_abc(3, "midreset_abc");
  endtask

  task automatic test_random;
    logic [7:0] m[$];
    int         n;
    logic [511:0] snap;
    for (int t = 0; t < 12; t++) begin
      m.delete();
      n = $urandom_range(1, 62);
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      send_msg(m, 2, 1'b1);
      @(negedge clk);
`ifdef MD5_PAD_ERR_EN
      if (n > 55) begin
        checks++;
        if (len_err !== 1'b1 || mesg_valid !== 1'b0) begin
          errors++; $display("FAIL rand%0d_len_err: len_err=%b valid=%b required 1 0", t, len_err, mesg_valid);
        end
        continue;
      end
`endif
      checks++;
      if (mesg_valid !== 1'b1 || mesg_out !== model_block(m)) begin
        errors++; $display("FAIL rand%0d_block n=%0d: valid=%b got %h required %h", t, n, mesg_valid, mesg_out, model_block(m));
      end
      snap = mesg_out;
      repeat ($urandom_range(0, 4)) @(negedge clk);
      checks++;
      if (mesg_out !== snap || mesg_valid !== 1'b1) begin
        errors++; $display("FAIL rand%0d_stable: got %h required %h", t, mesg_out, snap);
      end
      mesg_ready = 1'b1;
      @(negedge clk);
      mesg_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_abc(0, "abc");
    test_max55();
    test_backpressure();
    test_overlength();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
